// File: rtl/conv_rx_mux_arb_if.sv
// Port bundle for conv_rx_mux_arb: per-channel RX FIFO heads in, merged
// packet stream out toward the transmit-enable FIFO.
interface conv_rx_mux_arb_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 64,
  parameter int MOD_W  = $clog2(DATA_W/8),
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]        pkt_avail_i;
  logic [NUM_CH*DATA_W-1:0] pkt_data_i;
  logic [NUM_CH-1:0]        pkt_sop_i;
  logic [NUM_CH-1:0]        pkt_eop_i;
  logic [NUM_CH*MOD_W-1:0]  pkt_mod_i;
  logic [NUM_CH-1:0]        frame_crc_err_i;
  logic [NUM_CH-1:0]        fifo_rd_req_o;
  logic                     tr_en_fifo_full_i;
  logic [DATA_W-1:0]        pkt_fifo_data_o;
  logic [7:0]               pkt_fifo_status_o;
  logic [2:0]               pkt_fifo_error_o;
  logic [15:0]              pkt_len_o;
  logic [CH_W-1:0]          pkt_chan_o;
  logic                     pkt_fifo_val_o;

  modport slave (
    input  pkt_avail_i, pkt_data_i, pkt_sop_i, pkt_eop_i, pkt_mod_i,
           frame_crc_err_i, tr_en_fifo_full_i,
    output fifo_rd_req_o, pkt_fifo_data_o, pkt_fifo_status_o,
           pkt_fifo_error_o, pkt_len_o, pkt_chan_o, pkt_fifo_val_o
  );

  modport master (
    output pkt_avail_i, pkt_data_i, pkt_sop_i, pkt_eop_i, pkt_mod_i,
           frame_crc_err_i, tr_en_fifo_full_i,
    input  fifo_rd_req_o, pkt_fifo_data_o, pkt_fifo_status_o,
           pkt_fifo_error_o, pkt_len_o, pkt_chan_o, pkt_fifo_val_o
  );
endinterface

// File: rtl/conv_rx_mux_arb.sv
// Round-robin packet arbiter over NUM_CH show-ahead RX FIFOs with length
// check/truncation, watchdog force-end and error-cause reporting.
module conv_rx_mux_arb #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 64,
  parameter int MOD_W       = $clog2(DATA_W/8),
  parameter int CRC_LEN     = 4,
  parameter int MIN_PKT_LEN = 64,
  parameter int MAX_PKT_LEN = 1518,
  parameter int WDT_TICKS   = 600
) (
  input logic              clk_i,
  input logic              rst_n_i,
  conv_rx_mux_arb_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BPW   = DATA_W/8;
  localparam int WDT_W = $clog2(WDT_TICKS+1);

  typedef enum logic [1:0] {IDLE_S, READ_S, DROP_S, ERR_END_S} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   gch, gch_nxt, ptr, ptr_nxt, cand, sel;
  logic              found;
  logic [15:0]       len_cnt, len_nxt, len_eop;
  logic [WDT_W-1:0]  wdt_cnt, wdt_nxt;
  logic [1:0]        cause, cause_nxt;  // {watchdog, length}; crc bit is implied

  logic              h_avail, h_sop, h_eop, h_crc;
  logic [DATA_W-1:0] h_data;
  logic [MOD_W-1:0]  h_mod;

  logic [NUM_CH-1:0] rd;
  logic              val, sop, eop;
  logic [DATA_W-1:0] data;
  logic [MOD_W-1:0]  mod_o;
  logic [2:0]        err;
  logic [15:0]       len_o;
  logic [7:0]        st;

  // Walk offsets high to low so the nearest channel past ptr wins.
  always_comb begin
    int idx;
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (bus.pkt_avail_i[idx]) begin
        found = 1'b1;
        cand  = CH_W'(idx);
      end
    end
  end

  assign sel     = (state == IDLE_S) ? cand : gch;
  assign h_avail = bus.pkt_avail_i[sel];
  assign h_sop   = bus.pkt_sop_i[sel];
  assign h_eop   = bus.pkt_eop_i[sel];
  assign h_crc   = bus.frame_crc_err_i[sel];
  assign h_data  = bus.pkt_data_i[int'(sel)*DATA_W +: DATA_W];
  assign h_mod   = bus.pkt_mod_i[int'(sel)*MOD_W +: MOD_W];
  assign len_eop = len_cnt + ((h_mod == '0) ? 16'(BPW) : 16'(h_mod));

  always_comb begin
    state_nxt = state;
    gch_nxt   = gch;
    ptr_nxt   = ptr;
    len_nxt   = len_cnt;
    wdt_nxt   = '0;
    cause_nxt = cause;
    rd        = '0;
    val       = 1'b0;
    sop       = 1'b0;
    eop       = 1'b0;
    data      = '0;
    mod_o     = '0;
    err       = '0;
    len_o     = '0;
    case (state)
      IDLE_S: begin
        len_nxt = 16'(CRC_LEN);
        if (found && !bus.tr_en_fifo_full_i) begin
          gch_nxt  = cand;
          ptr_nxt  = (int'(cand) == NUM_CH-1) ? '0 : CH_W'(cand + 1'b1);
          rd[cand] = 1'b1;
          if (h_sop && !h_eop) begin
            val       = 1'b1;
            sop       = 1'b1;
            data      = h_data;
            len_nxt   = 16'(CRC_LEN + BPW);
            state_nxt = READ_S;
          end else begin
            state_nxt = DROP_S;
          end
        end
      end
      READ_S: begin
        if (!h_avail) begin
          if (wdt_cnt == WDT_W'(WDT_TICKS-1)) begin
            state_nxt = ERR_END_S;
            cause_nxt = 2'b10;
          end else begin
            wdt_nxt = wdt_cnt + 1'b1;
          end
        end else if (h_sop) begin
          state_nxt = ERR_END_S;
          cause_nxt = 2'b00;
        end else begin
          rd[gch] = 1'b1;
          val     = 1'b1;
          data    = h_data;
          if (h_eop) begin
            eop       = 1'b1;
            mod_o     = h_mod;
            len_o     = len_eop;
            err[0]    = h_crc;
            err[1]    = (len_eop < 16'(MIN_PKT_LEN)) || (len_eop > 16'(MAX_PKT_LEN));
            len_nxt   = 16'(CRC_LEN);
            state_nxt = IDLE_S;
          end else begin
            len_nxt = len_cnt + 16'(BPW);
            // Truncate once the next word could push past the maximum.
            if (len_cnt + 16'(2*BPW) >= 16'(MAX_PKT_LEN)) begin
              state_nxt = ERR_END_S;
              cause_nxt = 2'b01;
            end else if (bus.tr_en_fifo_full_i) begin
              state_nxt = ERR_END_S;
              cause_nxt = 2'b00;
            end
          end
        end
      end
      ERR_END_S: begin
        val       = 1'b1;
        eop       = 1'b1;
        err       = {cause, 1'b1};
        len_o     = len_cnt + 16'(BPW);
        state_nxt = DROP_S;
      end
      DROP_S: begin
        if (h_avail) begin
          if (h_sop) begin
            len_nxt   = 16'(CRC_LEN);
            state_nxt = IDLE_S;
          end else begin
            rd[gch] = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE_S;
    endcase
  end

  always_comb begin
    st            = '0;
    st[7]         = sop;
    st[6]         = eop;
    st[MOD_W-1:0] = mod_o;
  end

  assign bus.fifo_rd_req_o     = rd;
  assign bus.pkt_fifo_val_o    = val;
  assign bus.pkt_fifo_data_o   = data;
  assign bus.pkt_fifo_status_o = st;
  assign bus.pkt_fifo_error_o  = err;
  assign bus.pkt_len_o         = len_o;
  assign bus.pkt_chan_o        = sel;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE_S;
      gch     <= '0;
      ptr     <= '0;
      len_cnt <= '0;
      wdt_cnt <= '0;
      cause   <= '0;
    end else begin
      state   <= state_nxt;
      gch     <= gch_nxt;
      ptr     <= ptr_nxt;
      len_cnt <= len_nxt;
      wdt_cnt <= wdt_nxt;
      cause   <= cause_nxt;
    end
  end
endmodule
